fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_if.sv | 29 ++
 rtl/fifo_rd_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between fifo_rd_ctrl, its sync FIFO and the downstream sink.
// slave = controller side, master = environment side.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             start_i;
  logic [LW-1:0]    len_i;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_rdata_i;
  logic             fifo_rd_en_o;
  logic             m_valid_o;
  logic [WIDTH-1:0] m_data_o;
  logic             m_ready_i;
  logic             busy_o;
  logic             done_o;

  modport slave (
    input  start_i, len_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
    output fifo_rd_en_o, m_valid_o, m_data_o, busy_o, done_o
  );

  modport master (
    output start_i, len_i, fifo_empty_i, fifo_rdata_i, m_ready_i,
    input  fifo_rd_en_o, m_valid_o, m_data_o, busy_o, done_o
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains len_i words from a sync FIFO into a valid/ready stream via a 2-entry skid buffer.
// Optional FIFO_RD_CTRL_CNT_EN adds rd_count_o, a 16-bit wrapping count of transfers.
module fifo_rd_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fifo_rd_ctrl_if.slave  bus
`ifdef FIFO_RD_CTRL_CNT_EN
  ,
  output logic [15:0]    rd_count_o
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    issue_cnt_q, issue_cnt_d;
  logic [LW-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic [1:0]       count_q;
  logic             wr_ptr_q, rd_ptr_q, inflight_q;
  logic [WIDTH-1:0] buf_q [2];
  logic [1:0]       occ;
  logic             rd_en, xfer, m_valid, busy, done;

  // A word arriving this cycle is already presented, so its slot counts as occupied.
  assign occ     = count_q + {1'b0, inflight_q};
  assign rd_en   = (state_q == BUSY) && !bus.fifo_empty_i && (issue_cnt_q != '0) && (occ < 2'd2);
  assign m_valid = (count_q != 2'd0) || inflight_q;
  assign xfer    = m_valid && bus.m_ready_i;

  assign bus.fifo_rd_en_o = rd_en;
  assign bus.m_valid_o    = m_valid;
  assign bus.m_data_o     = !m_valid ? '0 : ((count_q != 2'd0) ? buf_q[rd_ptr_q] : bus.fifo_rdata_i);
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            state_d     = BUSY;
            issue_cnt_d = bus.len_i;
            xfer_cnt_d  = bus.len_i;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (rd_en && (issue_cnt_q != '0)) issue_cnt_d = issue_cnt_q - LW'(1);
        if (xfer && (xfer_cnt_q != '0))   xfer_cnt_d  = xfer_cnt_q - LW'(1);
        if (xfer_cnt_q == '0)             state_d     = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every returning word is written at wr_ptr; a word consumed on arrival advances both pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      count_q    <= occ - {1'b0, xfer};
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (xfer)       rd_ptr_q <= ~rd_ptr_q;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        buf_q[gi] <= '0;
      end else if (inflight_q && (wr_ptr_q == 1'(gi))) begin
        buf_q[gi] <= bus.fifo_rdata_i;
      end
    end
  end

`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0] rd_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rd_count_q <= 16'd0;
    else if (xfer) rd_count_q <= rd_count_q + 16'd1;
  end

  assign rd_count_o = rd_count_q;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: a queue-based FIFO model feeds the DUT, every word
// written is pushed to the expected queue, and a negedge monitor checks each presented word.
module tb_fifo_rd_ctrl;
  localparam int W  = 4;
  localparam int D  = 16;
  localparam int LW = $clog2(D) + 1;

  logic clk;
  logic rst;
  fifo_rd_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus();
`ifdef FIFO_RD_CTRL_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_rd_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef FIFO_RD_CTRL_CNT_EN
    ,
    .rd_count_o (rd_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  int drain_len, rd_cnt, xfer_cnt, done_cnt, valid_cycles;
  int done_cyc, first_xfer_cyc, last_xfer_cyc, start_cyc;
  int reads_tot, xfers_tot;
  bit busy1, prev_stall, drain_over;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] fq[$];
  logic         wr_req;
  logic [W-1:0] wr_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic chk_eq(input string name, input int act, input int req);
    check(name, act == req, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural sync FIFO: read data registered one cycle after the read request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      bus.fifo_rdata_i <= '0;
      bus.fifo_empty_i <= 1'b1;
    end else begin
      if (bus.fifo_rd_en_o && fq.size() > 0) bus.fifo_rdata_i <= fq.pop_front();
      if (wr_req) fq.push_back(wr_data);
      bus.fifo_empty_i <= (fq.size() == 0);
    end
  end

  // Monitor: every presented word must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rst) begin
      reads_tot  = 0;
      xfers_tot  = 0;
      prev_stall = 1'b0;
    end else begin
      if (cyc == start_cyc + 1) busy1 = bus.busy_o;
      if (prev_stall) chk_eq("valid_held", int'(bus.m_valid_o), 1);
      if (bus.m_valid_o) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_word: got %0d, required no word", bus.m_data_o);
        end else begin
          chk_eq("m_data", int'(bus.m_data_o), int'(exp_q[0]));
          if (bus.m_ready_i) void'(exp_q.pop_front());
        end
        if (bus.m_ready_i) begin
          xfer_cnt++;
          xfers_tot++;
          if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
        end
      end
      if (bus.fifo_rd_en_o) begin
        chk_eq("rd_while_empty", int'(bus.fifo_empty_i), 0);
        rd_cnt++;
        reads_tot++;
        check("outstanding_le_2", (reads_tot - xfers_tot) <= 2, reads_tot - xfers_tot, 2);
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk_eq("done_after_last", xfer_cnt, drain_len);
      end
      prev_stall = bus.m_valid_o && !bus.m_ready_i;
    end
  end

  task automatic fifo_write(input logic [W-1:0] d);
    wr_data = d;
    wr_req  = 1'b1;
    exp_q.push_back(d);
    step();
    wr_req  = 1'b0;
  endtask

  task automatic drain_init(input int len);
    drain_len      = len;
    rd_cnt         = 0;
    xfer_cnt       = 0;
    done_cnt       = 0;
    valid_cycles   = 0;
    done_cyc       = -1;
    first_xfer_cyc = -1;
    last_xfer_cyc  = -1;
    busy1          = 1'b0;
    drain_over     = 1'b0;
  endtask

  task automatic chk_outputs_zero();
    chk_eq("rst_fifo_rd_en", int'(bus.fifo_rd_en_o), 0);
    chk_eq("rst_m_valid", int'(bus.m_valid_o), 0);
    chk_eq("rst_m_data", int'(bus.m_data_o), 0);
    chk_eq("rst_busy", int'(bus.busy_o), 0);
    chk_eq("rst_done", int'(bus.done_o), 0);
  endtask

  // rmode: 0 ready held high, 1 ready toggled after 1..10 cycle holds, 2 ready random per cycle.
  task automatic run_drain(input int len, input int npre, input int gmin, input int gmax,
                           input int rmode, input bit timing_chk);
    int c0;
    drain_init(len);
    for (int i = 0; i < npre; i++) fifo_write(W'($urandom));
    bus.m_ready_i = (rmode == 0) || ($urandom_range(0, 1) == 1);
    c0            = cyc;
    start_cyc     = c0;
    bus.start_i   = 1'b1;
    bus.len_i     = LW'(len);
    step();
    bus.start_i   = 1'b0;
    bus.len_i     = '0;
    fork
      begin
        for (int i = npre; i < len; i++) begin
          repeat ($urandom_range(gmin, gmax)) step();
          fifo_write(W'($urandom));
        end
      end
      begin
        while (!drain_over) begin
          if (rmode == 1) begin
            bus.m_ready_i = !bus.m_ready_i;
            repeat ($urandom_range(1, 10)) step();
          end else begin
            if (rmode == 2) bus.m_ready_i = ($urandom_range(0, 1) == 1);
            step();
          end
        end
      end
      begin
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
          step();
          n++;
        end
        if (done_cnt == 0) check("done_timeout", 1'b0, n, 3000);
        repeat (4) step();
        drain_over = 1'b1;
      end
    join
    bus.m_ready_i = 1'b1;
    step();
    $display("drain len=%0d pre=%0d rmode=%0d words_out=%0d reads=%0d done=%0d",
             len, npre, rmode, xfer_cnt, rd_cnt, done_cnt);
    chk_eq("done_count", done_cnt, 1);
    chk_eq("reads_issued", rd_cnt, len);
    chk_eq("words_out", xfer_cnt, len);
    chk_eq("words_left", exp_q.size(), 0);
    chk_eq("busy_after_start", int'(busy1), int'(len > 0));
    if (len == 0) begin
      chk_eq("len0_done_cycle", done_cyc - c0, 1);
      chk_eq("len0_valid_cycles", valid_cycles, 0);
    end
    if (timing_chk) begin
      chk_eq("first_valid_latency", first_xfer_cyc - c0, 2);
      chk_eq("burst_span", last_xfer_cyc - first_xfer_cyc, len - 1);
    end
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.len_i     = '0;
    bus.m_ready_i = 1'b1;
    wr_req        = 1'b0;
    wr_data       = '0;
    start_cyc     = -10;
    drain_init(0);

    repeat (3) step();
    chk_outputs_zero();
`ifdef FIFO_RD_CTRL_CNT_EN
    chk_eq("rst_rd_count", int'(rd_count), 0);
`endif
    rst = 1'b0;
    step();

    run_drain(16, 16, 0, 0, 0, 1'b1);
    run_drain(0, 0, 0, 0, 0, 1'b0);
    run_drain(4, 0, 3, 3, 0, 1'b0);
    run_drain(8, 8, 0, 0, 1, 1'b0);

    // Reset in the middle of an 8-word drain, then restart on the first edge after release.
    drain_init(8);
    for (int i = 0; i < 8; i++) fifo_write(W'($urandom));
    bus.m_ready_i = 1'b1;
    start_cyc     = cyc;
    bus.start_i   = 1'b1;
    bus.len_i     = LW'(8);
    step();
    bus.start_i   = 1'b0;
    bus.len_i     = '0;
    n = 0;
    while (xfer_cnt < 3 && n < 200) begin
      step();
      n++;
    end
    if (xfer_cnt < 3) check("mid_reset_timeout", 1'b0, xfer_cnt, 3);
    rst = 1'b1;
    #1;
    chk_outputs_zero();
    chk_eq("xfers_before_rst", xfer_cnt, 3);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    run_drain(2, 0, 0, 2, 0, 1'b0);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    run_drain(5, 5, 0, 0, 0, 1'b1);
    run_drain(7, 3, 0, 2, 2, 1'b0);
`ifdef FIFO_RD_CTRL_CNT_EN
    chk_eq("rd_count_total", int'(rd_count), 12);
`endif

    for (int k = 0; k < 8; k++) begin
      int len;
      len = $urandom_range(0, D);
      run_drain(len, $urandom_range(0, len), 0, $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
